// File: rtl/mult_div_unit_pkg.sv
// mips_defs: shared HI/LO unit encodings and latencies.
// Also used by the decoder that generates useMD.
package mips_defs;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) ||
             (op == MD_DIV)  || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// md_compute: single-shot combinational MULT/DIV datapath.
// Signed divide works on magnitudes so MIN/-1 wraps cleanly.
module md_compute
   import mips_defs::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        dbz_o
);

   logic        sgn;
   logic        div;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_div;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_res;
   logic [31:0] r_res;
   logic        q_neg;
   logic        r_neg;

   // operand conditioning, product, quotient and remainder
   always_comb begin
      sgn   = (op_i == MD_MULT) || (op_i == MD_DIV);
      div   = is_div(op_i);
      a_ext = sgn ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
      b_ext = sgn ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
      prod  = a_ext * b_ext;
      a_mag = (sgn && a_i[31]) ? -a_i : a_i;
      b_mag = (sgn && b_i[31]) ? -b_i : b_i;
      b_div = (b_i == 32'd0) ? 32'd1 : b_mag;
      q_mag = a_mag / b_div;
      r_mag = a_mag % b_div;
      q_neg = sgn && (a_i[31] ^ b_i[31]);
      r_neg = sgn && a_i[31];
      q_res = q_neg ? -q_mag : q_mag;
      r_res = r_neg ? -r_mag : r_mag;
      dbz_o = div && (b_i == 32'd0);
      res_o = div ? {r_res, q_res} : prod;
   end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MULT/DIV engine owning HI/LO.
// Result is computed at issue and committed after a fixed latency.
module mult_div_unit
   import mips_defs::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   if (MULT_LAT < 1 || MULT_LAT > 15) begin : g_bad_mult_lat
      $error("MULT_LAT must be within 1..15");
   end
   if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
      $error("DIV_LAT must be within 1..15");
   end

   md_state_e   state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  lat_d;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] pend_hi_q;
   logic [31:0] pend_lo_q;
   logic        dbz_q;
   logic [63:0] res;
   logic        dbz;
   logic        idle;

   md_compute u_compute (
      .op_i  (md_op),
      .a_i   (rs_val),
      .b_i   (rt_val),
      .res_o (res),
      .dbz_o (dbz)
   );

   // latency to load and the combinational stall seen in the issue cycle
   always_comb begin
      idle  = (state_q == ST_IDLE);
      lat_d = is_div(md_op) ? 4'(DIV_LAT) : 4'(MULT_LAT);
      busy  = reset &&
              ((start && is_arith(md_op) && idle) ||
               (state_q == ST_RUN));
   end

   assign hi = hi_q;
   assign lo = lo_q;

   // issue/countdown FSM with HI/LO commit; ops arriving in RUN are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         dbz_q     <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  unique case (1'b1)
                     is_arith(md_op): begin
                        pend_hi_q <= res[63:32];
                        pend_lo_q <= res[31:0];
                        dbz_q     <= dbz;
                        cnt_q     <= lat_d;
                        state_q   <= ST_RUN;
                     end
                     (md_op == MD_MTHI): hi_q <= rs_val;
                     (md_op == MD_MTLO): lo_q <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               if (cnt_q == 4'd1) begin
                  if (!dbz_q) begin
                     hi_q <= pend_hi_q;
                     lo_q <= pend_lo_q;
                  end
                  cnt_q   <= 4'd0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               cnt_q   <= 4'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for the HI/LO unit.
// Driver queues expected commits; a negedge monitor checks busy/hi/lo.
module tb_mult_div_unit;
   import mips_defs::*;

   localparam int ML = MULT_LAT_DEF;
   localparam int DL = DIV_LAT_DEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   mult_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          t;
      int          done;
      bit          arith;
      bit          wr_hi;
      bit          wr_lo;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e_mon;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          free_c = 0;
   int          checks = 0;
   int          errors = 0;
   int          viol = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // reference: architectural effect of one op, from the ISA rules
   function automatic exp_t model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input int t);
      exp_t              e;
      longint            sa;
      longint            sb;
      longint unsigned   ua;
      longint unsigned   ub;
      logic [63:0]       p;
      longint            q;
      longint            r;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = 64'(a);
      ub = 64'(b);
      e = '{t: t, done: t + 1, arith: 1'b0, wr_hi: 1'b0,
            wr_lo: 1'b0, hi: 32'd0, lo: 32'd0};
      case (op)
         MD_MULT, MD_MULTU: begin
            p = (op == MD_MULT) ? 64'(sa * sb) : 64'(ua * ub);
            e.arith = 1'b1;
            e.done  = t + ML + 1;
            e.wr_hi = 1'b1;
            e.wr_lo = 1'b1;
            e.hi    = p[63:32];
            e.lo    = p[31:0];
         end
         MD_DIV, MD_DIVU: begin
            e.arith = 1'b1;
            e.done  = t + DL + 1;
            if (b != 32'd0) begin
               if (op == MD_DIV) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = longint'(ua / ub);
                  r = longint'(ua % ub);
               end
               e.wr_hi = 1'b1;
               e.wr_lo = 1'b1;
               e.hi    = r[31:0];
               e.lo    = q[31:0];
            end
         end
         MD_MTHI: begin
            e.wr_hi = 1'b1;
            e.hi    = a;
         end
         MD_MTLO: begin
            e.wr_lo = 1'b1;
            e.lo    = a;
         end
         default: ;
      endcase
      return e;
   endfunction

   // monitor: retire due commits, then compare busy and HI/LO
   always @(negedge clk) begin
      bit eb;
      eb = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].done <= cyc) begin
         e_mon = exp_q.pop_front();
         if (e_mon.wr_hi) m_hi = e_mon.hi;
         if (e_mon.wr_lo) m_lo = e_mon.lo;
      end
      foreach (exp_q[i]) begin
         if (exp_q[i].arith && exp_q[i].t <= cyc) begin
            eb = 1'b1;
            if (start && md_op != MD_NONE && exp_q[i].t < cyc) viol++;
         end
      end
      chk("busy", 32'(busy), 32'(eb));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_free();
      while (cyc < free_c) step();
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      exp_t e;
      wait_free();
      start  = 1'b1;
      md_op  = op;
      rs_val = a;
      rt_val = b;
      e = model(op, a, b, cyc);
      if (op != MD_NONE) begin
         exp_q.push_back(e);
         free_c = e.done;
      end
      step();
      start  = 1'b0;
      md_op  = MD_NONE;
      rs_val = $urandom;
      rt_val = $urandom;
   endtask

   function automatic logic [31:0] rnd();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'h8000_0000;
         4: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      reset  = 1'b1;
      start  = 1'b0;
      md_op  = MD_NONE;
      rs_val = 32'd0;
      rt_val = 32'd0;
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      repeat (2) step();
      reset  = 1'b1;
      free_c = cyc;

      issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_free();
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);

      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_free();
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_free();
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);

      issue(MD_MTHI, 32'h11, 32'd0);
      issue(MD_MTLO, 32'h22, 32'd0);
      issue(MD_DIVU, 32'd100, 32'd0);
      wait_free();
      chk("dbz_hi", hi, 32'h11);
      chk("dbz_lo", lo, 32'h22);

      issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
      chk("mthi_hi", hi, 32'hDEAD_BEEF);
      chk("mthi_lo", lo, 32'h22);

      issue(MD_MULT, 32'd7, 32'd9);
      step();
      start  = 1'b1;
      md_op  = MD_MTLO;
      rs_val = 32'h1234_5678;
      step();
      start  = 1'b0;
      md_op  = MD_NONE;
      wait_free();
      chk("ign_lo", lo, 32'd63);

      issue(MD_DIV, 32'd1000, 32'hFFFF_FFF9);
      issue(MD_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_free();
      chk("b2b_hi", hi, 32'h0000_0000);
      chk("b2b_lo", lo, 32'h8000_0000);

      issue(MD_DIV, 32'd50, 32'd3);
      repeat (3) step();
      #1 reset = 1'b0;
      exp_q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      start = 1'b1;
      md_op = MD_MULT;
      #1;
      chk("rst_start_busy", 32'(busy), 32'd0);
      start = 1'b0;
      md_op = MD_NONE;
      repeat (2) step();
      reset  = 1'b1;
      free_c = cyc;

      issue(MD_MULT, 32'd3, 32'd4);
      wait_free();
      chk("m34_hi", hi, 32'd0);
      chk("m34_lo", lo, 32'd12);

      for (int k = 0; k < 60; k++) begin
         sel = $urandom_range(0, 9);
         a   = rnd();
         b   = rnd();
         case (sel)
            0, 1: op = MD_MULT;
            2:    op = MD_MULTU;
            3, 4: op = MD_DIV;
            5:    op = MD_DIVU;
            6:    op = MD_MTHI;
            7:    op = MD_MTLO;
            default: op = MD_NONE;
         endcase
         if (sel == 9) repeat ($urandom_range(1, 3)) step();
         else issue(op, a, b);
      end

      wait_free();
      repeat (2) step();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("illegal_issue", 32'(viol), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
